// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader state encoding, the word geometry, and the instruction
// field bit positions that the decode logic slices words with.
package imem_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  // Instruction field positions (R-type layout).
  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Byte packer: shifts accepted bytes into a word, most significant byte first.
// Ports:
//   clk, rst    clock, async active-high reset
//   clr         synchronous clear of the shift register and byte counter
//   push        a byte is accepted this cycle
//   byte_in     the byte being accepted
//   word        word as it will be after this cycle's push (shift reg + byte_in)
//   word_valid  this push completes a word (4th byte)
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [WORD_W-1:0] sreg;
  logic [1:0]        cnt;

  // Exposing the post-shift value lets the owner register the full word on
  // the same edge that accepts the 4th byte, giving a 1-cycle write latency.
  assign word       = {sreg[WORD_W-9:0], byte_in};
  assign word_valid = push && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (clr) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (push) begin
      sreg <= word;
      cnt  <= cnt + 2'd1;  // 3 -> 0 wrap starts the next word
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a byte stream into 32-bit words
// (MSB first) and writes them to consecutive word addresses from BASE_ADDR,
// holding the CPU until the load completes.
// Ports:
//   clk, rst               clock, async active-high reset
//   start, num_words       load request (sampled in IDLE only)
//   byte_in/valid/ready    byte stream handshake
//   imem_we/addr/wdata     instruction-memory write port
//   cpu_hold               stalls PC and gates regwrite while low-trust
//   busy, done, error      status (done/error sticky until next start)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

  state_e            state;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  word_cnt_inc;
  logic              push;
  logic              pk_clr;
  logic              last_byte;
  logic [WORD_W-1:0] word_nxt;

  // byte_ready is only high in RECV, so push implies RECV.
  assign push         = byte_valid & byte_ready;
  assign pk_clr       = (state == ST_IDLE) && start;
  assign word_cnt_inc = word_cnt + CNT_W'(1);

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .push       (push),
    .byte_in    (byte_in),
    .word       (word_nxt),
    .word_valid (last_byte)
  );

  // Outputs are registered and updated on state transitions so they line
  // up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      num_q      <= '0;
      word_cnt   <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_q     <= num_words;
            word_cnt  <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_hold  <= 1'b1;
            imem_addr <= BASE_ADDR;
            if (num_words == '0) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else if (32'(num_words) > DEPTH_U) begin
              state <= ST_ERR;
              error <= 1'b1;
            end else begin
              state      <= ST_RECV;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (last_byte) begin
            state      <= ST_WRITE;
            byte_ready <= 1'b0;
            imem_we    <= 1'b1;
            imem_wdata <= word_nxt;
          end
        end
        ST_WRITE: begin
          imem_addr <= imem_addr + 32'd4;
          word_cnt  <= word_cnt_inc;
          if (word_cnt_inc == num_q) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state      <= ST_RECV;
            byte_ready <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_words = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, imem_we, cpu_hold, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  logic [31:0] wbuf [0:DEPTH-1];

  imem_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every write pulse is counted; no byte may be accepted during a write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      we_count++;
      chk("ready_during_write", {31'b0, byte_ready}, 32'd0);
    end
  end

  // Load n words from wbuf; stall_pct = chance (%) byte_valid is low.
  // poke issues an extra start mid-RECV, which must be ignored.
  task automatic run_load(input int n, input int stall_pct, input bit poke, input string tag);
    int idx = 0;
    int cyc = 0;
    int total = 4 * n;
    int limit = 100 * n + 50;
    int base_we = we_count;
    bit poked = 0;
    bit xfer;
    int w;
    @(negedge clk);
    start = 1'b1; num_words = 16'(n);
    @(negedge clk);
    start = 1'b0;
    chk({tag, " hold_on_start"}, {31'b0, cpu_hold}, 32'd1);
    chk({tag, " done_cleared"},  {31'b0, done},     32'd0);
    chk({tag, " busy"},          {31'b0, busy},     32'd1);
    while (idx < total && cyc < limit) begin
      byte_valid = ($urandom_range(99) >= stall_pct);
      w = idx / 4;
      byte_in = byte_valid ? 8'(wbuf[w] >> (8 * (3 - idx % 4))) : 8'($urandom);
      if (poke && !poked && idx == 2) begin
        start = 1'b1; num_words = 16'd5; poked = 1;
      end
      xfer = byte_ready && byte_valid;
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (xfer) begin
        idx++;
        if (idx % 4 == 0) begin
          byte_valid = 1'b0;
          w = idx / 4 - 1;
          chk($sformatf("%s w%0d we", tag, w),    {31'b0, imem_we},    32'd1);
          chk($sformatf("%s w%0d addr", tag, w),  imem_addr,           BASE + 32'(4 * w));
          chk($sformatf("%s w%0d data", tag, w),  imem_wdata,          wbuf[w]);
          chk($sformatf("%s w%0d ready", tag, w), {31'b0, byte_ready}, 32'd0);
          chk($sformatf("%s w%0d early_done", tag, w), {31'b0, done},  32'd0);
          if (idx < total) @(negedge clk);
        end
      end
    end
    byte_valid = 1'b0;
    chk({tag, " bytes_accepted"}, 32'(idx), 32'(total));
    @(negedge clk);
    chk({tag, " done"},       {31'b0, done},     32'd1);
    chk({tag, " released"},   {31'b0, cpu_hold}, 32'd0);
    chk({tag, " busy_end"},   {31'b0, busy},     32'd0);
    chk({tag, " no_error"},   {31'b0, error},    32'd0);
    chk({tag, " final_addr"}, imem_addr,         BASE + 32'(4 * n));
    chk({tag, " write_cnt"},  32'(we_count - base_we), 32'(n));
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " hold"},  {31'b0, cpu_hold},   32'd1);
    chk({tag, " we"},    {31'b0, imem_we},    32'd0);
    chk({tag, " done"},  {31'b0, done},       32'd0);
    chk({tag, " error"}, {31'b0, error},      32'd0);
    chk({tag, " ready"}, {31'b0, byte_ready}, 32'd0);
    chk({tag, " busy"},  {31'b0, busy},       32'd0);
    chk({tag, " addr"},  imem_addr,           BASE);
    chk({tag, " wdata"}, imem_wdata,          32'd0);
  endtask

  initial begin
    int base_we;

    // Reset, then idle with no start
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("idle");

    // Single word: add $t2,$t0,$t1
    wbuf[0] = 32'h0109_5020;
    run_load(1, 0, 0, "single");

    // Multi-word with random stalls
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    run_load(3, 40, 0, "stall");

    // Restart while done=1, with an ignored start during RECV
    wbuf[0] = $urandom;
    run_load(1, 20, 1, "restart");

    // Overflow request
    base_we = we_count;
    @(negedge clk);
    start = 1'b1; num_words = 16'(DEPTH + 1);
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b1; byte_in = 8'hA5;
    chk("ovf error", {31'b0, error},    32'd1);
    chk("ovf hold",  {31'b0, cpu_hold}, 32'd1);
    chk("ovf done",  {31'b0, done},     32'd0);
    chk("ovf busy",  {31'b0, busy},     32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ovf ready%0d", i), {31'b0, byte_ready}, 32'd0);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    chk("ovf error_sticky", {31'b0, error}, 32'd1);
    chk("ovf no_write", 32'(we_count - base_we), 32'd0);

    // Zero-length request
    base_we = we_count;
    start = 1'b1; num_words = 16'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero done",     {31'b0, done},       32'd1);
    chk("zero error",    {31'b0, error},      32'd0);
    chk("zero released", {31'b0, cpu_hold},   32'd0);
    chk("zero ready",    {31'b0, byte_ready}, 32'd0);
    @(negedge clk);
    chk("zero no_write", 32'(we_count - base_we), 32'd0);

    // Full-capacity load
    for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
    run_load(DEPTH, 0, 0, "full");

    // Reset after 2 bytes of the first word
    base_we = we_count;
    start = 1'b1; num_words = 16'd2;
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b1; byte_in = 8'hDE;
    @(negedge clk);
    byte_in = 8'hAD;
    @(negedge clk);
    byte_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst = 1'b0;
    @(negedge clk);
    chk("midrst no_write", 32'(we_count - base_we), 32'd0);
    wbuf[0] = $urandom;
    run_load(1, 30, 0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
